// File: rtl/rle_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rle_pkg
// Purpose : Shared types and helpers for the run-length encoder/decoder pair.
//           Holds the encoder FSM state encoding and the maximum run length
//           function for a given count field width.
// Revision: 1.0 - initial release
// ============================================================================
package rle_pkg;

    // IDLE: no open run, RUN: run open, FLUSH: final run waiting for the slot
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rle_state_t;

    // Largest run length representable in a count field of count_w bits
    function automatic int max_run(input int count_w);
        return (1 << count_w) - 1;
    endfunction

endpackage : rle_pkg
`default_nettype wire

// File: rtl/rle_out_slot.sv
`default_nettype none
// ============================================================================
// Module  : rle_out_slot
// Purpose : Single-entry valid/ready holding register for the encoder output.
// Ports   : clk, reset       - clock, async active-high reset
//           i_load, i_data   - load a new entry (only while o_slot_free)
//           i_ready          - downstream accepts the held entry
//           o_valid, o_data  - held entry
//           o_slot_free      - register can take a new entry this cycle
// Revision: 1.0 - initial release
// ============================================================================
module rle_out_slot #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_slot_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Free when empty, or when the current entry leaves on this edge
    assign o_slot_free = !r_valid || i_ready;
    assign o_valid     = r_valid;
    assign o_data      = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule : rle_out_slot
`default_nettype wire

// File: rtl/rle_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module  : rle_stream_encoder
// Purpose : Streaming run-length encoder. Consumes symbols on a valid/ready
//           stream and produces (symbol, run length, last) pairs on a
//           valid/ready stream. Runs saturate at 2**COUNT_W-1; in_last closes
//           the current run and ends the block.
// Ports   : clk, reset                         - clock, async active-high reset
//           in_data/in_valid/in_last/in_ready  - symbol input stream
//           out_data/out_count/out_last/
//           out_valid/out_ready                - run pair output stream
// Revision: 1.0 - initial release
// ============================================================================
module rle_stream_encoder
    import rle_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int                 c_PAIR_W  = DATA_W + COUNT_W + 1;
    localparam logic [COUNT_W-1:0] c_MAX_RUN = COUNT_W'(max_run(COUNT_W));
    localparam logic [COUNT_W-1:0] c_ONE     = COUNT_W'(1);

    rle_state_t          r_state;
    logic [DATA_W-1:0]   r_cur_sym;
    logic [COUNT_W-1:0]  r_cur_cnt;

    logic                w_slot_free;
    logic                w_accept;
    logic                w_extend;
    logic                w_emit;
    logic [DATA_W-1:0]   w_emit_sym;
    logic [COUNT_W-1:0]  w_emit_cnt;
    logic                w_emit_last;
    logic [c_PAIR_W-1:0] w_slot_data;

    // FLUSH blocks input so the trailing run can use the slot first
    assign in_ready = w_slot_free && (r_state != ST_FLUSH);
    assign w_accept = in_valid && in_ready;
    // Beat continues the open run only if the counter still has headroom
    assign w_extend = (in_data == r_cur_sym) && (r_cur_cnt != c_MAX_RUN);

    // Pair to load into the output slot this cycle, if any
    always_comb begin
        w_emit      = 1'b0;
        w_emit_sym  = r_cur_sym;
        w_emit_cnt  = r_cur_cnt;
        w_emit_last = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && in_last) begin
                    w_emit      = 1'b1;
                    w_emit_sym  = in_data;
                    w_emit_cnt  = c_ONE;
                    w_emit_last = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_extend) begin
                        if (in_last) begin
                            w_emit      = 1'b1;
                            w_emit_cnt  = r_cur_cnt + c_ONE;
                            w_emit_last = 1'b1;
                        end
                    end else begin
                        // Run closed by a new symbol or saturation; the new
                        // beat opens the next run
                        w_emit = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_slot_free) begin
                    w_emit      = 1'b1;
                    w_emit_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cur_sym <= '0;
            r_cur_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !in_last) begin
                        r_cur_sym <= in_data;
                        r_cur_cnt <= c_ONE;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_extend) begin
                            if (in_last) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_cur_cnt <= r_cur_cnt + c_ONE;
                            end
                        end else begin
                            r_cur_sym <= in_data;
                            r_cur_cnt <= c_ONE;
                            r_state   <= in_last ? ST_FLUSH : ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_slot_free) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rle_out_slot #(
        .WIDTH (c_PAIR_W)
    ) u_out_slot (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_emit),
        .i_data      ({w_emit_sym, w_emit_cnt, w_emit_last}),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      (w_slot_data),
        .o_slot_free (w_slot_free)
    );

    assign {out_data, out_count, out_last} = w_slot_data;

endmodule : rle_stream_encoder
`default_nettype wire

// File: tb/tb_rle_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_rle_stream_encoder
// Purpose : Self-checking bench for rle_stream_encoder (DATA_W=8, COUNT_W=2).
//           Directed beat tables carry their expected pairs; a random phase
//           uses an independent run-length model. Expected pairs go to a
//           queue when a beat is accepted and are compared as pairs leave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rle_stream_encoder;

    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int MAXR = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    always #5 clk = ~clk;

    rle_stream_encoder #(
        .DATA_W  (DW),
        .COUNT_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [7:0]  d;
        logic        l;
        int          n;
        logic [10:0] e0;
        logic [10:0] e1;
    } vec_t;

    vec_t        tbl[$];
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_vec = 0;
    bit          use_model = 0;
    bit          rand_rdy = 0;
    int          low_cnt = 0;
    bit          prev_hold = 0;
    logic [10:0] prev_pair;

    // Independent reference model state
    logic [7:0]  m_sym;
    int          m_cnt;
    bit          m_open = 0;

    function automatic logic [10:0] pk(input logic [7:0] d, input int c, input logic l);
        logic [1:0] c2;
        c2 = c[1:0];
        return {d, c2, l};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [7:0] d, input logic l, input int n,
                           input logic [10:0] e0, input logic [10:0] e1);
        vec_t v;
        v.d = d; v.l = l; v.n = n; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endtask

    task automatic model_beat(input logic [7:0] d, input logic l);
        if (m_open && d == m_sym && m_cnt < MAXR) begin
            m_cnt++;
        end else begin
            if (m_open) exp_q.push_back(pk(m_sym, m_cnt, 1'b0));
            m_sym  = d;
            m_cnt  = 1;
            m_open = 1;
        end
        if (l) begin
            exp_q.push_back(pk(m_sym, m_cnt, 1'b1));
            m_open = 0;
        end
    endtask

    // Monitor: at the falling edge, values describe the handshakes of the
    // upcoming rising edge.
    always @(negedge clk) begin
        logic [10:0] e;
        if (reset) begin
            prev_hold = 0;
        end else begin
            if (!in_ready) low_cnt++;
            if (prev_hold) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_pair", {21'd0, out_data, out_count, out_last}, {21'd0, prev_pair});
            end
            if (out_valid) check("count_nonzero", {31'd0, (out_count != 0)}, 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got %0h expected none", {out_data, out_count, out_last});
                end else begin
                    e = exp_q.pop_front();
                    check("pair", {21'd0, out_data, out_count, out_last}, {21'd0, e});
                end
            end
            if (in_valid && in_ready) begin
                if (use_model) begin
                    model_beat(in_data, in_last);
                end else begin
                    if (tbl[cur_vec].n > 0) exp_q.push_back(tbl[cur_vec].e0);
                    if (tbl[cur_vec].n > 1) exp_q.push_back(tbl[cur_vec].e1);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_pair = {out_data, out_count, out_last};
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drive one beat from posedge+1 and hold it until accepted
    task automatic drive_beat(input logic [7:0] d, input logic l, input int vi);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        cur_vec  = vi;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else begin
                n++;
                if (n > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got no in_ready required in_ready=1 within 100 cycles");
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive_beat(tbl[i].d, tbl[i].l, i);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // 0-5: A,A,A,B,B,C(last)
        add_vec(8'h41, 0, 0, 0, 0);
        add_vec(8'h41, 0, 0, 0, 0);
        add_vec(8'h41, 0, 0, 0, 0);
        add_vec(8'h42, 0, 1, pk(8'h41, 3, 0), 0);
        add_vec(8'h42, 0, 0, 0, 0);
        add_vec(8'h43, 1, 2, pk(8'h42, 2, 0), pk(8'h43, 1, 1));
        // 6-12: seven 0x55, last on the seventh; saturation at 3
        add_vec(8'h55, 0, 0, 0, 0);
        add_vec(8'h55, 0, 0, 0, 0);
        add_vec(8'h55, 0, 0, 0, 0);
        add_vec(8'h55, 0, 1, pk(8'h55, 3, 0), 0);
        add_vec(8'h55, 0, 0, 0, 0);
        add_vec(8'h55, 0, 0, 0, 0);
        add_vec(8'h55, 1, 2, pk(8'h55, 3, 0), pk(8'h55, 1, 1));
        // 13: single beat block
        add_vec(8'h10, 1, 1, pk(8'h10, 1, 1), 0);
        // 14-16: X,X(last) then X(last)
        add_vec(8'h77, 0, 0, 0, 0);
        add_vec(8'h77, 1, 1, pk(8'h77, 2, 1), 0);
        add_vec(8'h77, 1, 1, pk(8'h77, 1, 1), 0);
        // 17-19: back-pressure sequence
        add_vec(8'h20, 0, 0, 0, 0);
        add_vec(8'h21, 0, 1, pk(8'h20, 1, 0), 0);
        add_vec(8'h21, 1, 1, pk(8'h21, 2, 1), 0);
        // 20-23: run with a pending pair, then reset
        add_vec(8'h41, 0, 0, 0, 0);
        add_vec(8'h41, 0, 0, 0, 0);
        add_vec(8'h41, 0, 0, 0, 0);
        add_vec(8'h41, 0, 1, pk(8'h41, 3, 0), 0);
        // 24-25: A,A(last) after reset
        add_vec(8'h41, 0, 0, 0, 0);
        add_vec(8'h41, 1, 1, pk(8'h41, 2, 1), 0);

        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data}, 32'd0);
        check("rst_out_count", {30'd0, out_count}, 32'd0);
        check("rst_out_last",  {31'd0, out_last}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic runs; FLUSH costs exactly one in_ready-low cycle
        low_cnt = 0;
        run_vecs(0, 5);
        idle(4);
        check("flush_stall_cycles", low_cnt, 32'd1);

        run_vecs(6, 12);
        idle(4);

        // Single beat: pair visible one cycle after acceptance
        run_vecs(13, 13);
        @(negedge clk);
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_pair", {21'd0, out_data, out_count, out_last}, {21'd0, pk(8'h10, 1, 1)});
        @(posedge clk);
        #1;
        idle(2);

        run_vecs(14, 16);
        idle(4);

        // Back-pressure: pending pair held, next beat offered but not taken
        out_ready = 1'b0;
        run_vecs(17, 18);
        cur_vec = 19; in_data = 8'h21; in_last = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_pair", {21'd0, out_data, out_count, out_last}, {21'd0, pk(8'h20, 1, 0)});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        run_vecs(19, 19);
        idle(4);

        // Reset during an open run with a pending pair
        out_ready = 1'b0;
        run_vecs(20, 23);
        @(negedge clk);
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        run_vecs(24, 25);
        idle(4);
        check("directed_queue_empty", exp_q.size(), 32'd0);

        // Random stream against the reference model
        use_model = 1;
        m_open = 0;
        rand_rdy = 1;
        begin
            logic [7:0] sym;
            logic       lst;
            sym = 8'd0;
            for (int i = 0; i < 400; i++) begin
                idle($urandom_range(0, 2));
                if ($urandom_range(0, 2) == 0) sym = 8'($urandom_range(0, 3));
                lst = (i == 399) || ($urandom_range(0, 9) == 0);
                drive_beat(sym, lst, 0);
            end
        end
        rand_rdy = 0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        check("random_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rle_stream_encoder
`default_nettype wire
